bp_mem_trace_initiator: RTL and testbench
=========================================

# bp_mem_trace_initiator

ROM-driven initiator for the CCE-to-memory command interface, the requesting end of the protocol that `bp_mem` answers. It fetches operations from a trace ROM, issues `mem_data_cmd` writes and `mem_cmd` reads, and waits for the matching `mem_resp` or `mem_data_resp`. Read data is compared against the expected block. It lets `bp_mem` and boot-ROM preload be verified standalone, without a core or CCE.

## Interface
- paddr_width_p, "inv", physical address width
- num_lce_p, "inv", LCE count; sizes the struct macros only
- lce_assoc_p, "inv", associativity; sizes the struct macros only
- cce_block_size_in_bytes_p, "inv", block size; block_bits = 8*this
- rom_addr_width_p, "inv", trace ROM address width
- timeout_cycles_p, 1024, watchdog limit; used only with the timeout macro
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- rom_addr_o  out  rom_addr_width_p  trace ROM address
- rom_data_i  in  4+paddr_width_p+block_bits  entry {op[3:0], addr, data}, op in the MSBs
- mem_cmd_o  out  `bp_cce_mem_cmd_width(...)`  read command: msg_type=read, addr=entry addr, other fields 0
- mem_cmd_v_o  out  1  read command valid
- mem_cmd_yumi_i  in  1  read command consumed
- mem_data_cmd_o  out  `bp_cce_mem_data_cmd_width(...)`  write command: msg_type=writeback, addr, data, other fields 0
- mem_data_cmd_v_o  out  1  write command valid
- mem_data_cmd_yumi_i  in  1  write command consumed
- mem_resp_i  in  `bp_mem_cce_resp_width(...)`  write ack; contents ignored
- mem_resp_v_i  in  1  write ack valid
- mem_resp_ready_o  out  1  write ack accept
- mem_data_resp_i  in  `bp_mem_cce_data_resp_width(...)`  read data response
- mem_data_resp_v_i  in  1  read data valid
- mem_data_resp_ready_o  out  1  read data accept
- done_o  out  1  sticky; trace finished or aborted
- error_o  out  1  sticky; mismatch, illegal op or timeout
- ops_cnt_o  out  32  completed read and write operations

## Operation
- States: FETCH, ISSUE_RD, ISSUE_WR, WAIT_RD, WAIT_WR, DONE.
- FETCH: decode `rom_data_i` at the current `rom_addr_o`.
  - op 4'h0 (nop): rom_addr+1, stay in FETCH.
  - op 4'h1 (write): latch addr and data, go to ISSUE_WR.
  - op 4'h2 (read-check): latch addr and expected data, go to ISSUE_RD.
  - op 4'h3 (finish): go to DONE.
  - Any other op: set error_o, go to DONE.
- ISSUE_x: the relevant command valid is high. Payload is from the latched registers, so it stays stable. Valid does not depend on yumi. On yumi, go to WAIT_x the next cycle.
- WAIT_WR: `mem_resp_ready_o`=1. On `mem_resp_v_i`: ops_cnt+1, rom_addr+1, go to FETCH.
- WAIT_RD: `mem_data_resp_ready_o`=1. On `mem_data_resp_v_i`, compare the response data field with the expected block.
  - Equal: ops_cnt+1, rom_addr+1, go to FETCH.
  - Different: set error_o, go to DONE.
- Response ready is high only in the matching WAIT state. A response of the wrong kind is never accepted and stalls upstream; this is not an error.
- DONE: set done_o. Terminal until reset; no valids asserted.
- rom_addr wraps mod 2^rom_addr_width_p. A trace without a finish op loops.
- ops_cnt saturates at 2^32-1.

## Timing
- Reset values: rom_addr_o=0, every *_v_o=0, every *_ready_o=0, done_o=0, error_o=0, ops_cnt_o=0, state=FETCH.
- The ROM is combinational, so a fetch takes 1 cycle.
- Command valid rises the cycle after the FETCH that decoded the op.
- Minimum write or read latency is 3 cycles: FETCH, ISSUE with yumi in the same cycle, WAIT with the response in the same cycle.
- A response arriving in the first WAIT cycle is accepted in that cycle.
- Reset asserted in any state returns all outputs to reset values at the next edge. Any outstanding transaction is abandoned; a late response sees ready=0.

## Configuration
- `BP_MEM_TRACE_INITIATOR_TIMEOUT_EN` defined:
  - A counter clears on entry to ISSUE_x or WAIT_x and increments each cycle spent there.
  - Reaching timeout_cycles_p sets error_o and goes to DONE.
- Undefined: no counter; the block waits indefinitely and timeout_cycles_p is unused.

## Test plan
- ROM {write 0x80 data A5..A5; read 0x80 expect A5..A5; finish}, yumi and responses immediate:
  - done_o=1, error_o=0, ops_cnt_o=2.
  - done_o rises 7 cycles after reset release.
- Read with expected 0x1, memory returns 0x0 -> error_o=1 and done_o=1 in the accept cycle+1; ops_cnt_o=0.
- `mem_cmd_yumi_i` held low 5 cycles -> mem_cmd_v_o stays 1 with constant payload for 6 cycles and is 0 the cycle after yumi.
- ROM entry 0 op 4'h7 -> error_o=1 and done_o=1 on cycle 2; no valid ever asserted.
- With the macro defined and timeout_cycles_p=16, no write ack ever sent -> error_o=1 exactly 16 cycles after WAIT_WR entry.
- reset_i pulsed while in WAIT_RD -> next cycle rom_addr_o=0 and all ready/valid outputs 0; rerunning the trace passes.

Source files
------------

// File: rtl/bp_mem_trace_initiator.sv
// Trace-ROM driven requester for the CCE-to-memory command interface: issues writes and
// checked reads from ROM entries. Optional watchdog: define BP_MEM_TRACE_INITIATOR_TIMEOUT_EN.
module bp_mem_trace_initiator #(
    parameter int paddr_width_p              = 22,
    parameter int num_lce_p                  = 1,
    parameter int lce_assoc_p                = 8,
    parameter int cce_block_size_in_bytes_p  = 64,
    parameter int rom_addr_width_p           = 8,
    parameter int timeout_cycles_p           = 1024,
    localparam int block_bits_lp             = 8 * cce_block_size_in_bytes_p,
    localparam int lce_id_width_lp           = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int way_id_width_lp           = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int msg_type_width_lp         = 2,
    localparam int hdr_width_lp              = msg_type_width_lp + paddr_width_p
                                               + lce_id_width_lp + way_id_width_lp,
    localparam int rom_data_width_lp         = 4 + paddr_width_p + block_bits_lp,
    localparam int mem_cmd_width_lp          = hdr_width_lp,
    localparam int mem_data_cmd_width_lp     = hdr_width_lp + block_bits_lp,
    localparam int mem_resp_width_lp         = hdr_width_lp,
    localparam int mem_data_resp_width_lp    = hdr_width_lp + block_bits_lp
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    output logic [rom_addr_width_p-1:0]       rom_addr_o,
    input  logic [rom_data_width_lp-1:0]      rom_data_i,

    output logic [mem_cmd_width_lp-1:0]       mem_cmd_o,
    output logic                              mem_cmd_v_o,
    input  logic                              mem_cmd_yumi_i,

    output logic [mem_data_cmd_width_lp-1:0]  mem_data_cmd_o,
    output logic                              mem_data_cmd_v_o,
    input  logic                              mem_data_cmd_yumi_i,

    input  logic [mem_resp_width_lp-1:0]      mem_resp_i,
    input  logic                              mem_resp_v_i,
    output logic                              mem_resp_ready_o,

    input  logic [mem_data_resp_width_lp-1:0] mem_data_resp_i,
    input  logic                              mem_data_resp_v_i,
    output logic                              mem_data_resp_ready_o,

    output logic                              done_o,
    output logic                              error_o,
    output logic [31:0]                       ops_cnt_o
);

    // Message layout, MSB first: {msg_type, addr, lce_id, way_id[, data]}; data sits in the LSBs.
    localparam int payload_width_lp = lce_id_width_lp + way_id_width_lp;

    localparam logic [2:0] s_fetch    = 3'd0;
    localparam logic [2:0] s_issue_rd = 3'd1;
    localparam logic [2:0] s_issue_wr = 3'd2;
    localparam logic [2:0] s_wait_rd  = 3'd3;
    localparam logic [2:0] s_wait_wr  = 3'd4;
    localparam logic [2:0] s_done     = 3'd5;

    localparam logic [3:0] op_nop    = 4'h0;
    localparam logic [3:0] op_write  = 4'h1;
    localparam logic [3:0] op_read   = 4'h2;
    localparam logic [3:0] op_finish = 4'h3;

    localparam logic [msg_type_width_lp-1:0] msg_rd = 2'd0;
    localparam logic [msg_type_width_lp-1:0] msg_wb = 2'd1;

    logic [2:0]                  state_q, state_d;
    logic [rom_addr_width_p-1:0] rom_addr_q, rom_addr_d;
    logic [paddr_width_p-1:0]    addr_q, addr_d;
    logic [block_bits_lp-1:0]    data_q, data_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic [31:0]                 ops_cnt_q, ops_cnt_d;

    logic [3:0]                  rom_op;
    logic [paddr_width_p-1:0]    rom_paddr;
    logic [block_bits_lp-1:0]    rom_block;
    logic [block_bits_lp-1:0]    resp_data;
    logic                        op_complete;
    logic                        abort;
    logic                        wd_expired;

    assign {rom_op, rom_paddr, rom_block} = rom_data_i;
    assign resp_data = mem_data_resp_i[block_bits_lp-1:0];

`ifdef BP_MEM_TRACE_INITIATOR_TIMEOUT_EN
    localparam int wd_width_lp = $clog2(timeout_cycles_p + 1);

    logic [wd_width_lp-1:0] wd_cnt_q, wd_cnt_d;

    // Any state change restarts the count, so ISSUE and WAIT each get a fresh budget.
    always_comb begin
        wd_cnt_d = (state_d != state_q) ? '0 : wd_cnt_q + wd_width_lp'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expired = (wd_cnt_q == wd_width_lp'(timeout_cycles_p - 1));
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = (timeout_cycles_p == 0);
`endif

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        error_d     = error_q;
        ops_cnt_d   = ops_cnt_q;
        op_complete = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            s_fetch: begin
                case (rom_op)
                    op_nop: rom_addr_d = rom_addr_q + rom_addr_width_p'(1);
                    op_write: begin
                        addr_d  = rom_paddr;
                        data_d  = rom_block;
                        state_d = s_issue_wr;
                    end
                    op_read: begin
                        addr_d  = rom_paddr;
                        data_d  = rom_block;
                        state_d = s_issue_rd;
                    end
                    op_finish: begin
                        done_d  = 1'b1;
                        state_d = s_done;
                    end
                    default: abort = 1'b1;
                endcase
            end
            s_issue_rd: begin
                if (mem_cmd_yumi_i) begin
                    state_d = s_wait_rd;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            s_issue_wr: begin
                if (mem_data_cmd_yumi_i) begin
                    state_d = s_wait_wr;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            s_wait_wr: begin
                if (mem_resp_v_i) begin
                    op_complete = 1'b1;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            s_wait_rd: begin
                if (mem_data_resp_v_i) begin
                    if (resp_data == data_q) begin
                        op_complete = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            s_done: begin
            end
            default: abort = 1'b1;
        endcase

        if (op_complete) begin
            rom_addr_d = rom_addr_q + rom_addr_width_p'(1);
            state_d    = s_fetch;
            if (ops_cnt_q != '1) begin
                ops_cnt_d = ops_cnt_q + 32'd1;
            end
        end

        if (abort) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = s_done;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= s_fetch;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ops_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ops_cnt_q  <= ops_cnt_d;
        end
    end

    // Operand latches only matter while a command is outstanding, so they carry no reset.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign rom_addr_o            = rom_addr_q;
    assign mem_cmd_v_o           = (state_q == s_issue_rd);
    assign mem_data_cmd_v_o      = (state_q == s_issue_wr);
    assign mem_resp_ready_o      = (state_q == s_wait_wr);
    assign mem_data_resp_ready_o = (state_q == s_wait_rd);
    assign mem_cmd_o             = {msg_rd, addr_q, payload_width_lp'(0)};
    assign mem_data_cmd_o        = {msg_wb, addr_q, payload_width_lp'(0), data_q};
    assign done_o                = done_q;
    assign error_o               = error_q;
    assign ops_cnt_o             = ops_cnt_q;

    logic unused_inputs;

    assign unused_inputs = ^{mem_resp_i, mem_data_resp_i[mem_data_resp_width_lp-1:block_bits_lp]};

endmodule

// File: tb/tb_bp_mem_trace_initiator.sv
// Bench for bp_mem_trace_initiator: table of short traces, hand-written handshake/reset
// sequences, and random traces checked against a trace interpreter.
module tb_bp_mem_trace_initiator;

    localparam int PA = 16;
    localparam int RA = 4;
    localparam int BB = 64;
    localparam int HW = 21;
    localparam int RW = 4 + PA + BB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RA-1:0]   rom_addr;
    logic [RW-1:0]   rom_data;
    logic [HW-1:0]   mem_cmd;
    logic            mem_cmd_v, mem_cmd_yumi;
    logic [HW+BB-1:0] mem_data_cmd;
    logic            mem_data_cmd_v, mem_data_cmd_yumi;
    logic [HW-1:0]   mem_resp;
    logic            mem_resp_v, mem_resp_ready;
    logic [HW+BB-1:0] mem_data_resp;
    logic            mem_data_resp_v, mem_data_resp_ready;
    logic            done, error;
    logic [31:0]     ops_cnt;

    logic            yumi_en = 1'b1, wr_resp_en = 1'b1, rd_resp_en = 1'b1;
    logic            wr_pend, rd_pend;
    logic [BB-1:0]   rd_data_q;
    logic [BB-1:0]   mem [256];
    logic [RW-1:0]   rom [16];

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bp_mem_trace_initiator #(
        .paddr_width_p(PA), .num_lce_p(2), .lce_assoc_p(4),
        .cce_block_size_in_bytes_p(8), .rom_addr_width_p(RA), .timeout_cycles_p(16)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_yumi_i(mem_cmd_yumi),
        .mem_data_cmd_o(mem_data_cmd), .mem_data_cmd_v_o(mem_data_cmd_v),
        .mem_data_cmd_yumi_i(mem_data_cmd_yumi),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_ready_o(mem_resp_ready),
        .mem_data_resp_i(mem_data_resp), .mem_data_resp_v_i(mem_data_resp_v),
        .mem_data_resp_ready_o(mem_data_resp_ready),
        .done_o(done), .error_o(error), .ops_cnt_o(ops_cnt)
    );

    assign rom_data          = rom[rom_addr];
    assign mem_cmd_yumi      = mem_cmd_v & yumi_en;
    assign mem_data_cmd_yumi = mem_data_cmd_v & yumi_en;
    assign mem_resp_v        = wr_pend & wr_resp_en;
    assign mem_data_resp_v   = rd_pend & rd_resp_en;
    assign mem_resp          = '0;
    assign mem_data_resp     = {{HW{1'b0}}, rd_data_q};

    // Fake memory: one outstanding command, data in a small array indexed by addr[7:0].
    always @(posedge clk) begin
        if (rst) begin
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (mem_data_cmd_v && mem_data_cmd_yumi) begin
                mem[mem_data_cmd[74:67]] <= mem_data_cmd[BB-1:0];
                wr_pend <= 1'b1;
            end else if (mem_resp_v && mem_resp_ready) begin
                wr_pend <= 1'b0;
            end
            if (mem_cmd_v && mem_cmd_yumi) begin
                rd_data_q <= mem[mem_cmd[10:3]];
                rd_pend   <= 1'b1;
            end else if (mem_data_resp_v && mem_data_resp_ready) begin
                rd_pend <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0][RW-1:0] prog;
        int                 cyc;
        logic               err;
        int                 ops;
    } vec_t;

    vec_t vt [8];

    function automatic logic [RW-1:0] ent(input logic [3:0] op, input logic [15:0] a,
                                          input logic [63:0] d);
        return {op, a, d};
    endfunction

    task automatic set_vec(input int i, input logic [RW-1:0] e0, e1, e2, e3,
                           input int cyc, input logic err, input int ops);
        vt[i].prog[0] = e0; vt[i].prog[1] = e1; vt[i].prog[2] = e2; vt[i].prog[3] = e3;
        vt[i].cyc = cyc; vt[i].err = err; vt[i].ops = ops;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd, output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (rnd) begin
                yumi_en    = ($urandom_range(0, 9) < 6);
                wr_resp_en = ($urandom_range(0, 9) < 6);
                rd_resp_en = ($urandom_range(0, 9) < 6);
            end
            step();
            cyc++;
        end
        yumi_en = 1'b1; wr_resp_en = 1'b1; rd_resp_en = 1'b1;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL run_to_done: done_o still 0 after %0d cycles", cyc);
        end
    endtask

    // Reference interpreter: walks the trace with its own memory image.
    logic [63:0] ref_mem [256];
    task automatic ref_run(output logic err, output int ops);
        logic [3:0] pc;
        logic [3:0] op;
        logic [7:0] a;
        logic [63:0] d;
        bit stop;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        pc = 0; ops = 0; err = 1'b0; stop = 0;
        for (int n = 0; n < 64 && !stop; n++) begin
            op = rom[pc][RW-1:RW-4];
            a  = rom[pc][71:64];
            d  = rom[pc][63:0];
            if (op == 4'h0) pc++;
            else if (op == 4'h1) begin ref_mem[a] = d; ops++; pc++; end
            else if (op == 4'h2) begin
                if (ref_mem[a] == d) begin ops++; pc++; end
                else begin err = 1'b1; stop = 1; end
            end
            else if (op == 4'h3) stop = 1;
            else begin err = 1'b1; stop = 1; end
        end
    endtask

    int          cyc;
    logic        exp_err;
    int          exp_ops;
    logic [63:0] shadow [4];
    logic [HW-1:0] exp_cmd;
    int          r, s;
    logic [63:0] d_r;

    localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

    initial begin
        set_vec(0, ent(1, 16'h80, A5), ent(2, 16'h80, A5), ent(3, 0, 0), ent(3, 0, 0), 7, 0, 2);
        set_vec(1, ent(2, 16'h40, 64'h1), ent(3, 0, 0), ent(3, 0, 0), ent(3, 0, 0), 3, 1, 0);
        set_vec(2, ent(7, 16'h0, 64'h0), ent(3, 0, 0), ent(3, 0, 0), ent(3, 0, 0), 1, 1, 0);
        set_vec(3, ent(0, 0, 0), ent(0, 0, 0), ent(1, 16'h10, 64'hD0D0), ent(3, 0, 0), 6, 0, 1);
        set_vec(4, ent(1, 16'h20, 64'h1111), ent(1, 16'h20, 64'h2222),
                ent(2, 16'h20, 64'h2222), ent(3, 0, 0), 10, 0, 3);
        set_vec(5, ent(2, 16'h30, 64'h0), ent(3, 0, 0), ent(3, 0, 0), ent(3, 0, 0), 4, 0, 1);
        set_vec(6, ent(0, 0, 0), ent(4'hF, 0, 0), ent(3, 0, 0), ent(3, 0, 0), 2, 1, 0);
        set_vec(7, ent(1, 16'h44, 64'h1234), ent(2, 16'h44, 64'h4321), ent(3, 0, 0),
                ent(3, 0, 0), 6, 1, 1);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) rom[i] = (i < 4) ? vt[v].prog[i] : ent(3, 0, 0);
            do_reset();
            if (v == 0) begin
                chk("reset rom_addr", 64'(rom_addr), 64'd0);
                chk("reset cmd_v", 64'(mem_cmd_v), 64'd0);
                chk("reset data_cmd_v", 64'(mem_data_cmd_v), 64'd0);
                chk("reset resp_ready", 64'(mem_resp_ready), 64'd0);
                chk("reset data_resp_ready", 64'(mem_data_resp_ready), 64'd0);
                chk("reset done", 64'(done), 64'd0);
                chk("reset error", 64'(error), 64'd0);
                chk("reset ops_cnt", 64'(ops_cnt), 64'd0);
            end
            run_to_done(0, cyc);
            chk($sformatf("vec%0d cycles", v), 64'(cyc), 64'(vt[v].cyc));
            chk($sformatf("vec%0d error", v), 64'(error), 64'(vt[v].err));
            chk($sformatf("vec%0d ops_cnt", v), 64'(ops_cnt), 64'(vt[v].ops));
            step();
            chk($sformatf("vec%0d idle valids", v),
                64'({mem_cmd_v, mem_data_cmd_v, mem_resp_ready, mem_data_resp_ready, done}),
                64'b00001);
        end

        // Read command held off by yumi for 5 cycles.
        for (int i = 0; i < 16; i++) rom[i] = ent(3, 0, 0);
        rom[0] = ent(2, 16'h80, 64'h0);
        exp_cmd = {2'd0, 16'h0080, 3'd0};
        yumi_en = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall cyc%0d cmd_v", i), 64'(mem_cmd_v), 64'd1);
            chk($sformatf("stall cyc%0d cmd", i), 64'(mem_cmd), 64'(exp_cmd));
            if (i == 5) yumi_en = 1'b1;
            step();
        end
        chk("stall after yumi cmd_v", 64'(mem_cmd_v), 64'd0);
        chk("stall data_resp_ready", 64'(mem_data_resp_ready), 64'd1);
        run_to_done(0, cyc);
        chk("stall error", 64'(error), 64'd0);
        chk("stall ops_cnt", 64'(ops_cnt), 64'd1);

        // Reset while waiting for read data, then rerun.
        rom[0] = ent(1, 16'h80, 64'h5A5A); rom[1] = ent(2, 16'h80, 64'h5A5A); rom[2] = ent(3, 0, 0);
        rd_resp_en = 1'b0;
        do_reset();
        repeat (5) step();
        chk("wait_rd data_resp_ready", 64'(mem_data_resp_ready), 64'd1);
        chk("wait_rd resp_ready", 64'(mem_resp_ready), 64'd0);
        chk("wait_rd rom_addr", 64'(rom_addr), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_resp_en = 1'b1;
        chk("mid reset rom_addr", 64'(rom_addr), 64'd0);
        chk("mid reset handshakes",
            64'({mem_cmd_v, mem_data_cmd_v, mem_resp_ready, mem_data_resp_ready}), 64'd0);
        chk("mid reset ops_cnt", 64'(ops_cnt), 64'd0);
        run_to_done(0, cyc);
        chk("rerun cycles", 64'(cyc), 64'd7);
        chk("rerun error", 64'(error), 64'd0);
        chk("rerun ops_cnt", 64'(ops_cnt), 64'd2);

`ifdef BP_MEM_TRACE_INITIATOR_TIMEOUT_EN
        // Write ack withheld: watchdog fires 16 cycles after WAIT_WR entry.
        rom[0] = ent(1, 16'h80, 64'h1); rom[1] = ent(3, 0, 0);
        wr_resp_en = 1'b0;
        do_reset();
        repeat (2) step();
        chk("wd wait_wr entry", 64'(mem_resp_ready), 64'd1);
        repeat (15) step();
        chk("wd before limit", 64'(error), 64'd0);
        step();
        chk("wd at limit error", 64'(error), 64'd1);
        chk("wd at limit done", 64'(done), 64'd1);
        wr_resp_en = 1'b1;
`endif

        // Random traces with random handshake stalls.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 4; k++) shadow[k] = '0;
            for (int i = 0; i < 15; i++) begin
                r = $urandom_range(0, 99);
                s = $urandom_range(0, 3);
                d_r = {$urandom, $urandom};
                if (r < 8) rom[i] = ent(0, 0, d_r);
                else if (r < 48) begin
                    rom[i] = ent(1, 16'(s * 8), d_r);
                    shadow[s] = d_r;
                end else if (r < 90) rom[i] = ent(2, 16'(s * 8), (r < 86) ? shadow[s] : d_r);
                else if (r < 94) rom[i] = ent(3, 0, d_r);
                else rom[i] = ent(4'($urandom_range(4, 15)), 16'(s * 8), d_r);
            end
            rom[15] = ent(3, 0, 0);
            ref_run(exp_err, exp_ops);
            do_reset();
            run_to_done(1, cyc);
            chk($sformatf("rand%0d done", t), 64'(done), 64'd1);
            chk($sformatf("rand%0d error", t), 64'(error), 64'(exp_err));
            chk($sformatf("rand%0d ops_cnt", t), 64'(ops_cnt), 64'(exp_ops));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
